inv_sub_bytes_seq: RTL and testbench

Sequential AES-128 decryption InvSubBytes stage. It accepts a full 128-bit cipher state over a valid/ready handshake and substitutes each byte through the FIPS-197 inverse S-box, BYTES_PER_CYCLE lookups per clock. It returns the substituted state over a second valid/ready handshake. It sits between the InvShiftRows stage (upstream) and the AddRoundKey stage (downstream) in the decrypt datapath. It lets the design trade area (number of inverse S-box instances) for latency.

---
 rtl/inv_sub_bytes_seq.sv | 166 ++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// AES-128 InvSubBytes: substitutes all 16 state bytes, BYTES_PER_CYCLE inverse S-box lookups per clock.
// Latency: 16/BYTES_PER_CYCLE + 1 cycles from input accept to out_valid; one state per 16/BPC + 2 cycles.
// Backpressure: in_ready is low while busy or holding a result; the result is held until out_ready.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NGRP = 16 / BYTES_PER_CYCLE;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LAST = NGRP - 1;

    // Only power-of-two lane counts dividing the 16-byte state are meaningful.
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 inverse S-box; row = high nibble, column = low nibble.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    wrk_q, wrk_d;
    logic [127:0]    out_q, out_d;
    logic            in_rdy_q, in_rdy_d;
    logic            out_vld_q, out_vld_d;
    logic            busy_q, busy_d;

    logic [7:0]      sb_in  [BYTES_PER_CYCLE];
    logic [7:0]      sb_out [BYTES_PER_CYCLE];

    // One inverse S-box per lane.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign sb_out[g] = INV_SBOX[sb_in[g]];
    end

    // Select the current byte group from the working register for the S-box lanes.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in[j] = wrk_q[8*(15 - (int'(cnt_q)*BYTES_PER_CYCLE + j)) +: 8];
        end
    end

    // Next-state logic: handshakes, in-place substitution, clr override.
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        wrk_d     = wrk_q;
        out_d     = out_q;
        in_rdy_d  = in_rdy_q;
        out_vld_d = out_vld_q;
        busy_d    = busy_q;

        case (st_q)
            S_IDLE: begin
                if (in_valid && in_rdy_q) begin
                    wrk_d    = state_in;
                    cnt_d    = '0;
                    st_d     = S_BUSY;
                    in_rdy_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_BUSY: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    wrk_d[8*(15 - (int'(cnt_q)*BYTES_PER_CYCLE + j)) +: 8] = sb_out[j];
                end
                if (cnt_q == CW'(LAST)) begin
                    // Result register loads the fully substituted state as DONE is entered.
                    st_d      = S_DONE;
                    cnt_d     = '0;
                    busy_d    = 1'b0;
                    out_vld_d = 1'b1;
                    out_d     = wrk_d;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    st_d      = S_IDLE;
                    out_vld_d = 1'b0;
                    in_rdy_d  = 1'b1;
                end
            end
            default: begin
                st_d      = S_IDLE;
                in_rdy_d  = 1'b1;
                out_vld_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Abort beats any handshake in the same cycle; the last result stays visible.
        if (clr) begin
            st_d      = S_IDLE;
            cnt_d     = '0;
            wrk_d     = wrk_q;
            out_d     = out_q;
            in_rdy_d  = 1'b1;
            out_vld_d = 1'b0;
            busy_d    = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= S_IDLE;
            cnt_q     <= '0;
            wrk_q     <= '0;
            out_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            wrk_q     <= wrk_d;
            out_q     <= out_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign state_out = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances with BYTES_PER_CYCLE = 1, 2, 4, 8, 16.
// Expected bytes come from an inverse S-box derived from GF(2^8) arithmetic and the AES affine map.
// Directed steps followed by randomised handshake streams with a queue scoreboard.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   clr;
    logic [4:0]   in_valid;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [4:0]   out_ready;
    logic [4:0]   busy;
    logic [127:0] state_in  [5];
    logic [127:0] state_out [5];

    int checks   = 0;
    int failures = 0;

    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    // Instance g runs BYTES_PER_CYCLE = 2**g.
    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box = affine(GF inverse); the inverse table is its permutation inverse.
    task automatic build_table();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one state to an idle instance; returns at the negedge of the first BUSY cycle.
    task automatic send(input int i, input logic [127:0] d);
        @(negedge clk);
        in_valid[i] = 1'b1;
        state_in[i] = d;
        chk("send_in_ready", in_ready[i], 1);
        @(negedge clk);
        in_valid[i] = 1'b0;
        chk("send_busy", busy[i], 1);
    endtask

    // Counts cycles from the accept cycle until out_valid is seen (bounded).
    task automatic wait_valid(input int i, output int lat);
        lat = 1;
        while (!out_valid[i] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain(input int i);
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk("drain_out_valid", out_valid[i], 0);
        chk("drain_in_ready", in_ready[i], 1);
    endtask

    task automatic run_stream(input int i, input int n);
        logic [127:0] exq[$];
        logic [127:0] e;
        int  sent, got, cyc;
        bit  acc;
        sent = 0; got = 0; cyc = 0; acc = 1'b0;
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b0;
        while (got < n && cyc < 15000) begin
            @(negedge clk);
            cyc++;
            // Hold an offered state until it is taken.
            if (!(in_valid[i] && !acc)) begin
                if (sent < n && $urandom_range(0, 2) != 0) begin
                    in_valid[i] = 1'b1;
                    state_in[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
            out_ready[i] = 1'($urandom_range(0, 1));
            acc = in_valid[i] && in_ready[i];
            if (acc) begin
                exq.push_back(model(state_in[i]));
                sent++;
            end
            if (out_valid[i] && out_ready[i]) begin
                checks++;
                assert (exq.size() != 0) else begin
                    failures++;
                    $error("FAIL stream_extra_output observed=%h expected=none", state_out[i]);
                end
                if (exq.size() != 0) begin
                    e = exq.pop_front();
                    chk("stream_data", state_out[i], e);
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b0;
        chk("stream_count", got, n);
        chk("stream_leftover", exq.size(), 0);
    endtask

    initial begin
        int lat;
        logic [127:0] d, e;

        rst_n = 1'b0;
        clr = '0;
        in_valid = '0;
        out_ready = '0;
        for (int i = 0; i < 5; i++) state_in[i] = '0;
        build_table();
        repeat (3) @(negedge clk);

        // Reset values on every instance.
        for (int i = 0; i < 5; i++) begin
            chk("rst_in_ready", in_ready[i], 1);
            chk("rst_out_valid", out_valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_state_out", state_out[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // BPC=1 known vector, 17-cycle latency.
        send(0, 128'h000102030405060708090a0b0c0d0e0f);
        wait_valid(0, lat);
        chk("t1_latency", lat, 17);
        chk("t1_data", state_out[0], 128'h52096ad53036a538bf40a39e81f3d7fb);
        chk("t1_busy_done", busy[0], 0);
        drain(0);

        // BPC=16: single BUSY cycle, latency 2.
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(4, d);
        wait_valid(4, lat);
        chk("bpc16_latency", lat, 2);
        chk("bpc16_data", state_out[4], model(d));
        drain(4);

        // BPC=8 latency 3.
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(3, d);
        wait_valid(3, lat);
        chk("bpc8_latency", lat, 3);
        chk("bpc8_data", state_out[3], model(d));
        drain(3);

        // BPC=4 uniform-byte vectors.
        send(2, {16{8'h63}});
        wait_valid(2, lat);
        chk("t2_latency", lat, 5);
        chk("t2_zero", state_out[2], {16{8'h00}});
        drain(2);
        send(2, {16{8'hff}});
        wait_valid(2, lat);
        chk("t2_7d", state_out[2], {16{8'h7d}});
        drain(2);

        // Backpressure in DONE: result held, new input refused.
        d = 128'h0123456789abcdeffedcba9876543210;
        e = model(d);
        send(2, d);
        wait_valid(2, lat);
        in_valid[2] = 1'b1;
        state_in[2] = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_out_valid_held", out_valid[2], 1);
            chk("t3_state_held", state_out[2], e);
            chk("t3_in_ready_low", in_ready[2], 0);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b0;
        chk("t3_one_transfer", out_valid[2], 0);
        chk("t3_in_ready_back", in_ready[2], 1);
        chk("t3_not_accepted", busy[2], 0);
        @(negedge clk);
        chk("t3_still_idle", busy[2], 0);

        // Asynchronous reset at BUSY counter 7 (BPC=1).
        send(0, {$urandom(), $urandom(), $urandom(), $urandom()});
        repeat (7) @(negedge clk);
        chk("t4_busy_before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_in_ready", in_ready[0], 1);
        chk("t4_rst_out_valid", out_valid[0], 0);
        chk("t4_rst_busy", busy[0], 0);
        chk("t4_rst_state_out", state_out[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, d);
        wait_valid(0, lat);
        chk("t4_latency", lat, 17);
        chk("t4_data", state_out[0], model(d));
        drain(0);

        // clr in DONE together with out_ready (BPC=2).
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        e = model(d);
        send(1, d);
        wait_valid(1, lat);
        chk("t5_latency", lat, 9);
        clr[1] = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        out_ready[1] = 1'b0;
        chk("t5_out_valid", out_valid[1], 0);
        chk("t5_in_ready", in_ready[1], 1);
        chk("t5_state_kept", state_out[1], e);
        // clr beats in_valid in IDLE.
        clr[1] = 1'b1;
        in_valid[1] = 1'b1;
        state_in[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        clr[1] = 1'b0;
        in_valid[1] = 1'b0;
        chk("t5_clr_wins_busy", busy[1], 0);
        chk("t5_clr_wins_ready", in_ready[1], 1);
        // clr mid-BUSY discards the partial result.
        send(1, {$urandom(), $urandom(), $urandom(), $urandom()});
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        chk("t5_abort_busy", busy[1], 0);
        chk("t5_abort_state", state_out[1], e);
        repeat (10) @(negedge clk);
        chk("t5_abort_no_out", out_valid[1], 0);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(1, d);
        wait_valid(1, lat);
        chk("t5_after_abort_lat", lat, 9);
        chk("t5_after_abort_data", state_out[1], model(d));
        drain(1);

        // Randomised streams.
        run_stream(0, 200);
        run_stream(1, 200);
        run_stream(4, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
